data_buffer_arbiter: RTL and testbench
======================================

# data_buffer_arbiter

Controls and time-shares the 64-byte endpoint data buffer between the AHB-Lite slave (1/2/4-byte word accesses) and the USB side (RX byte stores, TX byte fetches). It owns the FIFO read/write pointers and the buffer occupancy count. It drives the single-port 64x8 storage array and answers the protocol controller's `clear`. It sits between the AHB-Lite slave, the RX/TX byte paths, and the storage array.

## Interface
- `DEPTH`, 64, buffer size in bytes (power of two)
- `ADDR_W`, 6, log2(DEPTH)
- `clk`  in  1  clock
- `n_rst`  in  1  reset, asynchronous, active-low
- `clear`  in  1  synchronous buffer clear, from protocol controller
- `flush`  in  1  synchronous buffer clear, from AHB slave
- `ahb_req`  in  1  start word access; sampled only in IDLE
- `ahb_write`  in  1  1 = store TX data into buffer, 0 = fetch RX data
- `ahb_size`  in  2  0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes; 3 is treated as 4
- `ahb_wdata`  in  32  write word, little-endian
- `ahb_rdata`  out  32  read word, valid while `ahb_done` = 1
- `ahb_done`  out  1  one-cycle completion pulse
- `ahb_err`  out  1  qualifies `ahb_done`: overflow, underflow or abort occurred
- `usb_store`  in  1  RX byte store request (single-cycle pulse)
- `usb_wdata`  in  8  RX byte
- `usb_get`  in  1  TX byte fetch request (single-cycle pulse)
- `usb_rdata`  out  8  fetched TX byte
- `mem_addr`  out  ADDR_W  storage address
- `mem_we`  out  1  storage write enable
- `mem_wdata`  out  8  storage write data
- `mem_rdata`  in  8  storage read data, combinational from `mem_addr`
- `buffer_occupancy`  out  7  bytes held, 0..64
- `empty`  out  1  occupancy == 0
- `full`  out  1  occupancy == 64

## Operation
- Pointers: `wr_ptr` and `rd_ptr` are ADDR_W bits and wrap modulo DEPTH. The occupancy counter is 7 bits.
- Each store increments `wr_ptr` and occupancy. Each fetch increments `rd_ptr` and decrements occupancy.
- The storage port performs one access per cycle. The USB side has absolute priority.
- When `usb_store` is high, the block writes `usb_wdata` at `wr_ptr`.
- When `usb_get` is high, the block reads at `rd_ptr` and registers the byte to `usb_rdata`.
- In either USB case, a pending AHB beat stalls for that cycle.
- If `usb_store` and `usb_get` are high together, which is illegal, the store is serviced and the get is dropped.
- USB store when full: the byte is dropped and the pointers are unchanged.
- USB get when empty: `usb_rdata` = 0x00 and the pointers are unchanged.
- AHB FSM has three states: IDLE, XFER and DONE.
  - IDLE → XFER on `ahb_req`. In that cycle the block latches write, size and wdata, sets beat count = 1<<size, and clears the error flag.
  - XFER performs one byte beat per non-stolen cycle. Beat k uses byte lane k (bits 8k+7:8k).
  - Write beat: `mem_we` = 1, address = `wr_ptr`. If full, the beat is skipped and the error flag is set.
  - Read beat: address = `rd_ptr`, and the block captures `mem_rdata` into lane k. If empty, lane k = 0x00 and the error flag is set.
  - XFER → DONE after the last beat.
  - DONE asserts `ahb_done` and `ahb_err` for one cycle, then returns to IDLE.
- `clear` or `flush`, in any state, highest priority:
  - `wr_ptr`, `rd_ptr` and occupancy go to 0 at the next edge.
  - No storage write occurs that cycle.
  - A transfer in XFER is abandoned: go to DONE with `ahb_err` = 1. Lanes not yet read return 0x00.
- When there is no access: `mem_addr` = `rd_ptr`, `mem_we` = 0.

## Timing
- Reset values:
  - Pointers, occupancy, `ahb_rdata`, `ahb_done`, `ahb_err`, `usb_rdata`, `mem_we`, `mem_wdata`, `mem_addr` and `full` are all 0.
  - `empty` = 1.
  - FSM is in IDLE.
- `mem_addr`, `mem_we` and `mem_wdata` are combinational from state and requests. Storage writes at the clock edge.
- `usb_rdata` updates on the edge ending the `usb_get` cycle and holds until the next get.
- Occupancy and flags update on the edge ending each access.
- AHB latency is `ahb_req` at cycle 0, beats in cycles 1..N, and `ahb_done` in cycle N+1. Each USB-stolen cycle adds 1.
- A new `ahb_req` is accepted no earlier than the cycle after DONE.
- An asynchronous reset mid-transfer discards the transfer. No `ahb_done` is issued.

## Structure
- Package `usb_buffer_pkg` holds:
  - DEPTH and ADDR_W constants
  - the size encodings
  - the AHB FSM state enum
- Sub-module `buffer_ptr_ctrl` holds `wr_ptr`, `rd_ptr`, occupancy, `full`/`empty` and the clear logic. Its inputs are `inc_wr`, `inc_rd` and `clr`.

## Test plan
- **4-byte AHB store:** AHB store, size 2, wdata 0x44332211, empty buffer → writes 11, 22, 33, 44 at addresses 0..3 → `ahb_done` at cycle 5, occupancy 4, `ahb_err` 0.
- **USB steal:** 4-byte AHB read with `usb_store` pulsed in cycle 2 → `ahb_done` delayed to cycle 6. The RX byte lands at `wr_ptr`. Occupancy is consistent.
- **Wrap-around:** 64 USB stores, then 62 gets, then 3 stores → `full` asserts after store 64. `wr_ptr` wraps to 0..2. Occupancy ends at 5.
- **Underflow:** 2-byte AHB read with occupancy 1 → lane 1 = 0x00, `ahb_err` = 1, occupancy 0.
- **Clear mid-transfer:** `clear` during beat 2 of a 4-byte read → next `ahb_done` has `ahb_err` = 1. Pointers and occupancy are 0, `empty` = 1.
- **Overflow and async reset:** USB store when full → no `mem_we`, occupancy stays 64. Async `n_rst` mid-XFER → all outputs return to their reset values immediately.

Source files
------------

// File: rtl/data_buffer_arbiter_pkg.sv
// Shared constants and types for the endpoint data buffer arbiter.
//   DEPTH / ADDR_W : buffer geometry (64 bytes, 6-bit pointers)
//   ahb_size_e     : AHB access size encodings
//   ahb_state_e    : AHB-side transfer FSM states
//   size_to_beats  : byte beats needed for a given access size
package usb_buffer_pkg;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } ahb_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } ahb_state_e;

    // Encoding 3 is not a legal AHB size here; it is treated as a word access.
    function automatic logic [2:0] size_to_beats(input logic [1:0] size);
        case (size)
            SIZE_BYTE: size_to_beats = 3'd1;
            SIZE_HALF: size_to_beats = 3'd2;
            default:   size_to_beats = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/data_buffer_arbiter_if.sv
// Client-side bus of the data buffer arbiter: the AHB word-access handshake
// plus the USB RX store / TX fetch byte paths.
//   master : AHB slave + USB byte paths (drive requests, receive data)
//   slave  : data_buffer_arbiter
interface data_buffer_arbiter_if;
    logic        ahb_req;
    logic        ahb_write;
    logic [1:0]  ahb_size;
    logic [31:0] ahb_wdata;
    logic [31:0] ahb_rdata;
    logic        ahb_done;
    logic        ahb_err;
    logic        usb_store;
    logic [7:0]  usb_wdata;
    logic        usb_get;
    logic [7:0]  usb_rdata;

    modport master (
        output ahb_req, ahb_write, ahb_size, ahb_wdata,
        input  ahb_rdata, ahb_done, ahb_err,
        output usb_store, usb_wdata, usb_get,
        input  usb_rdata
    );

    modport slave (
        input  ahb_req, ahb_write, ahb_size, ahb_wdata,
        output ahb_rdata, ahb_done, ahb_err,
        input  usb_store, usb_wdata, usb_get,
        output usb_rdata
    );
endinterface

// File: rtl/data_buffer_arbiter_buffer_ptr_ctrl.sv
// FIFO pointer / occupancy bookkeeping for the endpoint buffer.
//   clk, n_rst     : clock, async active-low reset
//   clr            : synchronous clear of both pointers and occupancy
//   inc_wr, inc_rd : one store / one fetch completed this cycle (never both)
//   wr_ptr, rd_ptr : byte pointers, wrap modulo DEPTH
//   occupancy      : bytes held, 0..DEPTH
//   full, empty    : occupancy == DEPTH / occupancy == 0
module buffer_ptr_ctrl
    import usb_buffer_pkg::*;
#(
    parameter int P_DEPTH  = DEPTH,
    parameter int P_ADDR_W = ADDR_W
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                clr,
    input  logic                inc_wr,
    input  logic                inc_rd,
    output logic [P_ADDR_W-1:0] wr_ptr,
    output logic [P_ADDR_W-1:0] rd_ptr,
    output logic [P_ADDR_W:0]   occupancy,
    output logic                full,
    output logic                empty
);

    localparam logic [P_ADDR_W:0] FULL_CNT = (P_ADDR_W+1)'(P_DEPTH);

    logic [P_ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [P_ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [P_ADDR_W:0]   occ_q, occ_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (inc_wr) wr_ptr_d = wr_ptr_q + 1'b1;
            if (inc_rd) rd_ptr_d = rd_ptr_q + 1'b1;
            case ({inc_wr, inc_rd})
                2'b10:   occ_d = occ_q + 1'b1;
                2'b01:   occ_d = occ_q - 1'b1;
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign wr_ptr    = wr_ptr_q;
    assign rd_ptr    = rd_ptr_q;
    assign occupancy = occ_q;
    assign full      = (occ_q == FULL_CNT);
    assign empty     = (occ_q == '0);

endmodule

// File: rtl/data_buffer_arbiter.sv
// Time-shares the single-port 64x8 endpoint buffer between the AHB-Lite slave
// (1/2/4-byte word accesses, one byte beat per cycle) and the USB byte paths
// (RX store, TX fetch). USB always wins the storage port; an AHB beat that
// loses the port simply waits a cycle.
//   clk, n_rst       : clock, async active-low reset
//   clear, flush     : synchronous buffer clear (protocol ctrl / AHB slave)
//   bus              : AHB + USB client interface (slave modport)
//   mem_addr/we/wdata: storage port, combinational from state and requests
//   mem_rdata        : storage read data, combinational from mem_addr
//   buffer_occupancy : bytes held; empty / full flags
module data_buffer_arbiter
    import usb_buffer_pkg::*;
#(
    parameter int P_DEPTH  = DEPTH,
    parameter int P_ADDR_W = ADDR_W
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   clear,
    input  logic                   flush,
    data_buffer_arbiter_if.slave   bus,
    output logic [P_ADDR_W-1:0]    mem_addr,
    output logic                   mem_we,
    output logic [7:0]             mem_wdata,
    input  logic [7:0]             mem_rdata,
    output logic [P_ADDR_W:0]      buffer_occupancy,
    output logic                   empty,
    output logic                   full
);

    ahb_state_e          state_q, state_d;
    logic                write_q, write_d;
    logic [2:0]          beats_q, beats_d;
    logic [1:0]          beat_q, beat_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [7:0]          usb_rdata_q, usb_rdata_d;

    logic                clr;
    logic                inc_wr, inc_rd;
    logic [P_ADDR_W-1:0] wr_ptr, rd_ptr;

    assign clr = clear | flush;

    buffer_ptr_ctrl #(
        .P_DEPTH  (P_DEPTH),
        .P_ADDR_W (P_ADDR_W)
    ) u_ptr (
        .clk       (clk),
        .n_rst     (n_rst),
        .clr       (clr),
        .inc_wr    (inc_wr),
        .inc_rd    (inc_rd),
        .wr_ptr    (wr_ptr),
        .rd_ptr    (rd_ptr),
        .occupancy (buffer_occupancy),
        .full      (full),
        .empty     (empty)
    );

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        beats_d     = beats_q;
        beat_d      = beat_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        usb_rdata_d = usb_rdata_q;
        mem_addr    = rd_ptr;
        mem_we      = 1'b0;
        mem_wdata   = '0;
        inc_wr      = 1'b0;
        inc_rd      = 1'b0;

        if (clr) begin
            // Clear overrides everything: no storage access this cycle and
            // an in-flight transfer is reported as aborted.
            if (state_q == ST_XFER) begin
                state_d = ST_DONE;
                err_d   = 1'b1;
            end else if (state_q == ST_DONE) begin
                state_d = ST_IDLE;
            end
        end else begin
            // USB side owns the port whenever it asks; a simultaneous get
            // with a store is illegal and is dropped.
            if (bus.usb_store) begin
                mem_addr = wr_ptr;
                if (!full) begin
                    mem_we    = 1'b1;
                    mem_wdata = bus.usb_wdata;
                    inc_wr    = 1'b1;
                end
            end else if (bus.usb_get) begin
                mem_addr = rd_ptr;
                if (empty) begin
                    usb_rdata_d = 8'h00;
                end else begin
                    usb_rdata_d = mem_rdata;
                    inc_rd      = 1'b1;
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (bus.ahb_req) begin
                        state_d = ST_XFER;
                        write_d = bus.ahb_write;
                        beats_d = size_to_beats(bus.ahb_size);
                        beat_d  = '0;
                        wdata_d = bus.ahb_wdata;
                        // Zeroed up front so lanes never read (abort) return 0.
                        rdata_d = '0;
                        err_d   = 1'b0;
                    end
                end
                ST_XFER: begin
                    if (!(bus.usb_store || bus.usb_get)) begin
                        if (write_q) begin
                            mem_addr = wr_ptr;
                            if (full) begin
                                err_d = 1'b1;
                            end else begin
                                mem_we    = 1'b1;
                                mem_wdata = wdata_q[8*beat_q +: 8];
                                inc_wr    = 1'b1;
                            end
                        end else begin
                            mem_addr = rd_ptr;
                            if (empty) begin
                                rdata_d[8*beat_q +: 8] = 8'h00;
                                err_d                  = 1'b1;
                            end else begin
                                rdata_d[8*beat_q +: 8] = mem_rdata;
                                inc_rd                 = 1'b1;
                            end
                        end
                        beat_d = beat_q + 1'b1;
                        if ({1'b0, beat_q} == beats_q - 3'd1) state_d = ST_DONE;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= ST_IDLE;
            write_q     <= 1'b0;
            beats_q     <= '0;
            beat_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            usb_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            beats_q     <= beats_d;
            beat_q      <= beat_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            usb_rdata_q <= usb_rdata_d;
        end
    end

    assign bus.ahb_done  = (state_q == ST_DONE);
    assign bus.ahb_err   = (state_q == ST_DONE) && err_q;
    assign bus.ahb_rdata = rdata_q;
    assign bus.usb_rdata = usb_rdata_q;

endmodule

// File: tb/tb_data_buffer_arbiter.sv
// Directed bench for data_buffer_arbiter with a behavioural 64x8 storage array.
module tb_data_buffer_arbiter;
    import usb_buffer_pkg::*;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        clear;
    logic        flush;
    logic [5:0]  mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic [6:0]  occ;
    logic        empty;
    logic        full;
    logic [7:0]  mem [0:63];

    int n_assert = 0;
    int n_fail   = 0;

    data_buffer_arbiter_if bus();

    data_buffer_arbiter dut (
        .clk              (clk),
        .n_rst            (n_rst),
        .clear            (clear),
        .flush            (flush),
        .bus              (bus),
        .mem_addr         (mem_addr),
        .mem_we           (mem_we),
        .mem_wdata        (mem_wdata),
        .mem_rdata        (mem_rdata),
        .buffer_occupancy (occ),
        .empty            (empty),
        .full             (full)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic usb_st(input logic [7:0] d);
        bus.usb_store = 1'b1;
        bus.usb_wdata = d;
        tick();
        bus.usb_store = 1'b0;
    endtask

    task automatic usb_gt();
        bus.usb_get = 1'b1;
        tick();
        bus.usb_get = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    // ev_kind: 0 none, 1 usb_store in cycle ev_cyc, 2 clear in cycle ev_cyc.
    // lat = cycle (req = cycle 0) in which ahb_done was seen, -1 if never.
    task automatic run_ahb(input logic wr, input logic [1:0] sz, input logic [31:0] wd,
                           input int ev_cyc, input int ev_kind,
                           output int lat, output logic [31:0] rd, output logic er);
        lat = -1;
        rd  = '0;
        er  = 1'b0;
        bus.ahb_write = wr;
        bus.ahb_size  = sz;
        bus.ahb_wdata = wd;
        for (int c = 0; c < 20; c++) begin
            bus.ahb_req   = (c == 0);
            bus.usb_store = (ev_kind == 1) && (c == ev_cyc);
            clear         = (ev_kind == 2) && (c == ev_cyc);
            @(negedge clk);
            if (bus.ahb_done) begin
                lat = c;
                rd  = bus.ahb_rdata;
                er  = bus.ahb_err;
                break;
            end
            @(posedge clk);
            #1;
        end
        bus.ahb_req   = 1'b0;
        bus.usb_store = 1'b0;
        clear         = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        er;
        int          done_seen;

        n_rst         = 1'b0;
        clear         = 1'b0;
        flush         = 1'b0;
        bus.ahb_req   = 1'b0;
        bus.ahb_write = 1'b0;
        bus.ahb_size  = 2'd0;
        bus.ahb_wdata = '0;
        bus.usb_store = 1'b0;
        bus.usb_wdata = '0;
        bus.usb_get   = 1'b0;

        // Reset values
        #12;
        chk("rst_occ",   occ, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full",  full, 0);
        chk("rst_done",  bus.ahb_done, 0);
        chk("rst_err",   bus.ahb_err, 0);
        chk("rst_rdata", bus.ahb_rdata, 0);
        chk("rst_urd",   bus.usb_rdata, 0);
        chk("rst_we",    mem_we, 0);
        chk("rst_addr",  mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        n_rst = 1'b1;
        tick();

        // 4-byte AHB store into empty buffer
        run_ahb(1'b1, 2'd2, 32'h44332211, 0, 0, lat, rd, er);
        chk("st4_lat", lat, 5);
        chk("st4_err", er, 0);
        chk("st4_occ", occ, 4);
        chk("st4_m0", mem[0], 8'h11);
        chk("st4_m1", mem[1], 8'h22);
        chk("st4_m2", mem[2], 8'h33);
        chk("st4_m3", mem[3], 8'h44);

        // 4-byte AHB read with a USB store stealing cycle 2
        bus.usb_wdata = 8'h55;
        run_ahb(1'b0, 2'd2, 32'h0, 2, 1, lat, rd, er);
        chk("steal_lat",   lat, 6);
        chk("steal_rdata", rd, 32'h44332211);
        chk("steal_err",   er, 0);
        chk("steal_occ",   occ, 1);
        chk("steal_m4",    mem[4], 8'h55);

        // USB get of the stolen byte, then get when empty
        usb_gt();
        chk("get_data",  bus.usb_rdata, 8'h55);
        chk("get_occ",   occ, 0);
        chk("get_empty", empty, 1);
        usb_gt();
        chk("get_empty_data", bus.usb_rdata, 8'h00);
        chk("get_empty_occ",  occ, 0);

        // Wrap-around, starting from zeroed pointers
        do_flush();
        chk("flush_occ", occ, 0);
        for (int i = 0; i < 63; i++) usb_st(8'(i));
        chk("wrap_full63", full, 0);
        usb_st(8'd63);
        chk("wrap_full64", full, 1);
        chk("wrap_occ64",  occ, 64);

        // Store while full is dropped
        bus.usb_store = 1'b1;
        bus.usb_wdata = 8'hAA;
        @(negedge clk);
        chk("ovf_we", mem_we, 0);
        @(posedge clk);
        #1;
        bus.usb_store = 1'b0;
        chk("ovf_occ", occ, 64);
        chk("ovf_m0",  mem[0], 8'h00);

        for (int i = 0; i < 62; i++) usb_gt();
        chk("wrap_lastget", bus.usb_rdata, 8'd61);
        chk("wrap_occ2",    occ, 2);
        for (int i = 0; i < 3; i++) begin
            bus.usb_store = 1'b1;
            bus.usb_wdata = 8'hA0 + 8'(i);
            @(negedge clk);
            chk("wrap_addr", mem_addr, i);
            @(posedge clk);
            #1;
            bus.usb_store = 1'b0;
        end
        chk("wrap_occ5", occ, 5);
        chk("wrap_m0",   mem[0], 8'hA0);
        chk("wrap_m2",   mem[2], 8'hA2);

        // Underflow: 2-byte read with one byte held
        do_flush();
        usb_st(8'h77);
        run_ahb(1'b0, 2'd1, 32'h0, 0, 0, lat, rd, er);
        chk("udf_lat",   lat, 3);
        chk("udf_rdata", rd, 32'h00000077);
        chk("udf_err",   er, 1);
        chk("udf_occ",   occ, 0);

        // Clear during beat 2 of a 4-byte read
        for (int i = 0; i < 4; i++) usb_st(8'h10 + 8'(i));
        run_ahb(1'b0, 2'd2, 32'h0, 2, 2, lat, rd, er);
        chk("clr_lat",   lat, 3);
        chk("clr_rdata", rd, 32'h00000010);
        chk("clr_err",   er, 1);
        chk("clr_occ",   occ, 0);
        chk("clr_empty", empty, 1);
        chk("clr_addr",  mem_addr, 0);

        // Async reset in the middle of a read transfer
        for (int i = 0; i < 3; i++) usb_st(8'hC0 + 8'(i));
        usb_gt();
        bus.ahb_write = 1'b0;
        bus.ahb_size  = 2'd2;
        bus.ahb_req   = 1'b1;
        tick();
        bus.ahb_req = 1'b0;
        tick();
        #2;
        n_rst = 1'b0;
        #1;
        chk("ar_occ",   occ, 0);
        chk("ar_empty", empty, 1);
        chk("ar_full",  full, 0);
        chk("ar_done",  bus.ahb_done, 0);
        chk("ar_rdata", bus.ahb_rdata, 0);
        chk("ar_urd",   bus.usb_rdata, 0);
        chk("ar_we",    mem_we, 0);
        chk("ar_addr",  mem_addr, 0);
        n_rst = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.ahb_done) done_seen++;
        end
        chk("ar_nodone", done_seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
